// File: rtl/baccarat_deal_fsm.sv
// Baccarat round sequencer.
// Issues one-cycle load strobes to the six hand card registers in deal order
// (P1, D1, P2, D2, then optional P3/D3). It tracks both hand scores from the
// card values it strobes in, applies the third-card rules, and registers the
// winner flags when the round ends.
//
// Ports:
//   slow_clock          clock, rising edge
//   reset               synchronous active-high reset
//   start               level request, sampled only in IDLE
//   new_card[3:0]       card value from the generator, valid while a strobe is high
//   load_pcard1..3      player card register load strobes
//   load_dcard1..3      dealer card register load strobes
//   pscore/dscore[3:0]  running hand scores, 0-9
//   busy                round in progress (not IDLE, not DONE)
//   done                round finished
//   player_win          player score >= dealer score (valid in DONE)
//   dealer_win          dealer score >= player score (valid in DONE)
module baccarat_deal_fsm (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] new_card,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       busy,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [3:0] {
    StIdle,
    StDealP1,
    StDealD1,
    StDealP2,
    StDealD2,
    StEval,
    StDealP3,
    StDchk,
    StDealD3,
    StResult,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pscore_q, pscore_d;
  logic [3:0] dscore_q, dscore_d;
  logic [3:0] pv_q, pv_d;          // point value of the player's third card
  logic       pwin_q, pwin_d;
  logic       dwin_q, dwin_d;

  logic [3:0] pts;
  logic [3:0] p_add;
  logic [3:0] d_add;
  logic       dealer_draw;

  // Face cards and out-of-range codes are worth nothing.
  function automatic logic [3:0] card_points(input logic [3:0] c);
    return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] s, input logic [3:0] p);
    logic [4:0] sum;
    sum = {1'b0, s} + {1'b0, p};
    if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

  // Dealer rule after the player has drawn; scores 8-9 cannot reach here.
  always_comb begin
    dealer_draw = 1'b0;
    case (dscore_q)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (pv_q != 4'd8);
      4'd4:             dealer_draw = (pv_q >= 4'd2) && (pv_q <= 4'd7);
      4'd5:             dealer_draw = (pv_q >= 4'd4) && (pv_q <= 4'd7);
      4'd6:             dealer_draw = (pv_q >= 4'd6) && (pv_q <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pscore_d = pscore_q;
    dscore_d = dscore_q;
    pv_d     = pv_q;
    pwin_d   = pwin_q;
    dwin_d   = dwin_q;
    pts      = card_points(new_card);
    p_add    = add_mod10(pscore_q, pts);
    d_add    = add_mod10(dscore_q, pts);

    case (state_q)
      StIdle: begin
        if (start) state_d = StDealP1;
      end
      StDealP1: begin
        pscore_d = p_add;
        state_d  = StDealD1;
      end
      StDealD1: begin
        dscore_d = d_add;
        state_d  = StDealP2;
      end
      StDealP2: begin
        pscore_d = p_add;
        state_d  = StDealD2;
      end
      StDealD2: begin
        dscore_d = d_add;
        state_d  = StEval;
      end
      StEval: begin
        if ((pscore_q >= 4'd8) || (dscore_q >= 4'd8)) begin
          state_d = StResult;
        end else if (pscore_q <= 4'd5) begin
          state_d = StDealP3;
        end else if (dscore_q <= 4'd5) begin
          state_d = StDealD3;
        end else begin
          state_d = StResult;
        end
      end
      StDealP3: begin
        pscore_d = p_add;
        pv_d     = pts;
        state_d  = StDchk;
      end
      StDchk: begin
        state_d = dealer_draw ? StDealD3 : StResult;
      end
      StDealD3: begin
        dscore_d = d_add;
        state_d  = StResult;
      end
      StResult: begin
        pwin_d  = (pscore_q >= dscore_q);
        dwin_d  = (dscore_q >= pscore_q);
        state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pscore_q <= 4'd0;
      dscore_q <= 4'd0;
      pv_q     <= 4'd0;
      pwin_q   <= 1'b0;
      dwin_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pscore_q <= pscore_d;
      dscore_q <= dscore_d;
      pv_q     <= pv_d;
      pwin_q   <= pwin_d;
      dwin_q   <= dwin_d;
    end
  end

  assign load_pcard1 = (state_q == StDealP1);
  assign load_dcard1 = (state_q == StDealD1);
  assign load_pcard2 = (state_q == StDealP2);
  assign load_dcard2 = (state_q == StDealD2);
  assign load_pcard3 = (state_q == StDealP3);
  assign load_dcard3 = (state_q == StDealD3);
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign pscore      = pscore_q;
  assign dscore      = dscore_q;
  assign player_win  = pwin_q;
  assign dealer_win  = dwin_q;

endmodule

// File: doc/baccarat_deal_fsm.md
# baccarat_deal_fsm

Round sequencer that drives the card-load side of the six 4-bit hand registers (player cards 1–3, dealer cards 1–3). It issues one-cycle load strobes in baccarat deal order, tracks both hand scores internally from the card values it strobes in, and applies the third-card drawing rules. It reports the winner when the round ends. It sits between the card generator (source of `new_card`) and the hand registers.

## Interface
- No parameters.
- `slow_clock`  in  1  — sole clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high; forces IDLE and clears all outputs and internal scores.
- `start`  in  1  — level input; sampled only in IDLE; begins a round.
- `new_card`  in  4  — card value 1–13 from the card generator; must be valid during any cycle a load strobe is high.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  — one-cycle load strobes to player card registers.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  — one-cycle load strobes to dealer card registers.
- `pscore`, `dscore`  out  4 each  — running player and dealer scores, 0–9.
- `busy`  out  1  — high in every state except IDLE and DONE.
- `done`  out  1  — high in DONE.
- `player_win`, `dealer_win`  out  1 each  — result flags, valid in DONE; both high means a tie.

## Operation
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, DCHK, DEAL_D3, RESULT, DONE.
- Load strobes are Moore outputs and are mutually exclusive. Exactly one strobe is high in each DEAL_* state; none are high elsewhere.
- In each DEAL_* state, `new_card` is captured by the hand register and by this block at the same edge.
- Card points: values 1–9 count face value; values 10–13 count 0; values 0, 14 and 15 are out of range and count 0.
- Score update: score ← (score + points) mod 10. Compute this in 5 bits, then subtract 10 if the result is 10 or more.
- Transitions:
  - IDLE → DEAL_P1 when `start` = 1.
  - DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → EVAL unconditionally.
- EVAL:
  - If `pscore` ≥ 8 or `dscore` ≥ 8 (natural), go to RESULT.
  - Else if `pscore` ≤ 5, go to DEAL_P3.
  - Else if `dscore` ≤ 5, go to DEAL_D3.
  - Else go to RESULT.
- DEAL_P3 → DCHK. The player third card's point value v is latched at this edge.
- DCHK: dealer draws (go to DEAL_D3) under these rules; otherwise go to RESULT.
  - `dscore` 0–2: always draws.
  - `dscore` 3: draws if v ≠ 8.
  - `dscore` 4: draws if v in 2–7.
  - `dscore` 5: draws if v in 4–7.
  - `dscore` 6: draws if v in 6–7.
  - `dscore` 7: never draws.
- DEAL_D3 → RESULT.
- RESULT → DONE. At this edge the block registers:
  - `player_win` = (`pscore` ≥ `dscore`)
  - `dealer_win` = (`dscore` ≥ `pscore`)
- DONE is terminal. `start` is ignored; only `reset` leaves DONE.
- `start` held high in IDLE starts exactly one round.

## Timing
- Reset value of every output is 0. Reset value of internal scores and v is 0. State after reset is IDLE.
- `reset` has priority over all other activity in any state, including mid-deal. Strobes drop in the cycle after the reset edge.
- Cycle numbering: cycle 0 is the IDLE cycle in which `start` = 1. Cycle n is n rising edges later.
- DEAL_P1 through DEAL_D2 occupy cycles 1–4; EVAL is cycle 5.
- `pscore` and `dscore` update on the edge that ends each DEAL_* cycle.
- DONE entry cycle by path:
  - Natural, or both stand: cycle 7.
  - Player stands, dealer draws: cycle 8.
  - Player draws, dealer stands: cycle 9.
  - Both draw: cycle 10.
- `busy` is high from cycle 1 through the RESULT cycle.
- `done`, `player_win` and `dealer_win` rise together in the same cycle.

## Test plan
- Natural. Cards P1=4, D1=2, P2=5, D2=3 → `pscore`=9, `dscore`=5. No third-card strobes. `done`=1 at cycle 7 with `player_win`=1, `dealer_win`=0.
- Dealer stands on 3 versus v=8. Cards P1=1, D1=10, P2=2, D2=3, P3=8 → `pscore`=1, `dscore`=3. `load_dcard3` never pulses. `done` at cycle 9 with `dealer_win`=1.
- Both draw. Cards P1=2, D1=13, P2=3, D2=4, P3=7, D3=3 → `pscore`=2, `dscore`=7. `done` at cycle 10 with `dealer_win`=1 only.
- Tie. Cards P1=6, D1=2, P2=10, D2=3, D3=1 → player stands on 6 and dealer draws on 5. Final scores 6 and 6. `done` at cycle 8 with both win flags = 1.
- Reset mid-deal. Assert `reset` during DEAL_D2 → the next cycle shows all outputs 0 and state IDLE. A fresh `start` then replays the full sequence from DEAL_P1.
- `start` handling.
  - `start` held high for 20 cycles → exactly one strobe sequence is issued.
  - A `start` pulse while in DONE → no strobes; outputs hold.
  - Each strobe is one cycle wide and never overlaps another strobe.
